rfphoenix_param_fifo: RTL and testbench
=======================================

RFPHOENIX_PARAM_FIFO -- requirements
Module: rfphoenix_param_fifo

Interface
REQ-001 Parameter WID, default 32: data width in bits, legal range 1..512.
REQ-002 Parameter DEP, default 16: depth in entries, power of two, legal range 4..1024; AW = log2(DEP).
REQ-003 Parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 Parameter AFULL, default DEP-2: almost_full threshold, legal range 1..DEP-1.
REQ-005 Port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port wr, input, 1 bit: write request.
REQ-008 Port di, input, WID bits: write data.
REQ-009 Port rd, input, 1 bit: read (pop) request.
REQ-010 Port dout, output, WID bits: read data.
REQ-011 Port valid, output, 1 bit: dout holds meaningful data.
REQ-012 Port cnt, output, AW+1 bits: occupancy, 0..DEP.
REQ-013 Port empty, output, 1 bit: cnt == 0.
REQ-014 Port full, output, 1 bit: cnt == DEP.
REQ-015 Port almost_full, output, 1 bit: cnt >= AFULL.
REQ-016 Port overflow, output, 1 bit: one-cycle pulse, write rejected.
REQ-017 Port underflow, output, 1 bit: one-cycle pulse, read rejected.

Function
REQ-018 Write accepted (wa) = wr & (!full | ra); an accepted write stores di at wr_ptr and advances wr_ptr by 1.
REQ-019 Read accepted (ra) = rd & !empty; an accepted read advances rd_ptr by 1.
REQ-020 Simultaneous wa and ra both take effect in the same cycle, and cnt is unchanged.
REQ-021 Pointers are AW+1 bits wide and wrap modulo 2*DEP; the low AW bits address storage.
REQ-022 cnt is a register: +1 on wa only, -1 on ra only, unchanged otherwise; cnt never exceeds DEP and never drops below 0.
REQ-023 empty, full, and almost_full are decoded combinationally from the cnt register.
REQ-024 The FIFO holds exactly DEP entries; full asserts only at cnt == DEP.
REQ-025 wr while full without ra: di is dropped, no state changes, and overflow = 1 for the next cycle.
REQ-026 rd while empty: no state changes, and underflow = 1 for the next cycle, even if wr is asserted the same cycle; that write is still accepted.
REQ-027 FWFT=0: dout is registered; dout equals the popped entry and valid = 1 the cycle after ra; valid = 0 in any cycle following no ra; dout holds its last value.
REQ-028 FWFT=1: dout is the head entry and valid = !empty; rd consumes the head; a word written to an empty FIFO appears on dout, with valid = 1, the cycle after the write.
REQ-029 Read-during-write to the same address cannot occur, because ra requires !empty; no bypass is needed.

Reset
REQ-030 Assertion of rst (low) asynchronously clears wr_ptr, rd_ptr, cnt, dout, valid, overflow, and underflow to 0, giving empty = 1, full = 0, and almost_full = 0.
REQ-031 Storage contents are not reset; all entries are logically discarded.
REQ-032 Reset during a write or read discards that operation and returns the FIFO to empty.
REQ-033 After deassertion, the first rising clk edge may accept wr.

Structure
REQ-034 Shared package rfphoenix_fifo_pkg holds the mode constants FIFO_REG = 0 and FIFO_FWFT = 1, and a log2 function for AW.
REQ-035 Storage is the sub-module rfphoenix_fifo_ram: simple dual-port, one write port and one asynchronous read port, DEP x WID, with no reset, so it infers distributed or block RAM.
REQ-036 The top level contains the pointers, counter, flags, and output register only.

Verification
REQ-037 Defaults, FWFT=0: write 16 words 0..15 -> full=1 and cnt=16 after the 16th; a 17th write -> overflow pulse and cnt stays 16; 16 reads -> dout sequence 0..15, each with valid one cycle after its rd.
REQ-038 cnt=8, then wr and rd held high for 20 cycles -> cnt stays 8, no overflow or underflow, and read data stays in write order across pointer wrap.
REQ-039 Full FIFO, wr=rd=1 -> write accepted, cnt stays 16, no overflow pulse; empty FIFO, wr=rd=1 -> underflow pulse and cnt=1.
REQ-040 FWFT=1: write 0xA5 into an empty FIFO -> next cycle valid=1 and dout=0xA5 with no rd; rd -> empty=1 and valid=0 the next cycle.
REQ-041 AFULL=14: almost_full=1 exactly when cnt reaches 14 and drops when cnt returns to 13.
REQ-042 rst low mid-burst at cnt=5 -> cnt=0, empty=1, and valid=0 immediately, with no clock edge required.

Source files
------------

// File: rtl/rfphoenix_fifo_pkg.sv
// Shared constants and helpers for the parameterised FIFO.
package rfphoenix_fifo_pkg;

  localparam int FIFO_REG  = 0;
  localparam int FIFO_FWFT = 1;

  // Ceiling log2, usable in parameter context; 1024 entries is the largest depth.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rfphoenix_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port, no reset.
module rfphoenix_fifo_ram #(
  parameter int WID = 32,
  parameter int DEP = 16,
  parameter int AW  = 4
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [WID-1:0] wdata,
  input  logic [AW-1:0]  raddr,
  output logic [WID-1:0] rdata
);

  logic [WID-1:0] mem_q [DEP];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rfphoenix_param_fifo.sv
// Parameterised synchronous FIFO with registered-read or first-word-fall-through output.
module rfphoenix_param_fifo
  import rfphoenix_fifo_pkg::*;
#(
  parameter int WID   = 32,
  parameter int DEP   = 16,
  parameter int FWFT  = FIFO_REG,
  parameter int AFULL = DEP - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [WID-1:0]       di,
  input  logic                 rd,
  output logic [WID-1:0]       dout,
  output logic                 valid,
  output logic [log2(DEP):0]   cnt,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int AW = log2(DEP);

  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic           overflow_q, overflow_d;
  logic           underflow_q, underflow_d;
  logic           ra, wa;
  logic [WID-1:0] rdata;

  assign empty       = (cnt_q == '0);
  assign full        = (cnt_q == (AW+1)'(DEP));
  assign almost_full = (cnt_q >= (AW+1)'(AFULL));
  assign cnt         = cnt_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
  always_comb begin
    ra          = rd & ~empty;
    wa          = wr & (~full | ra);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    overflow_d  = wr & full & ~ra;
    underflow_d = rd & empty;
    if (wa) wr_ptr_d = wr_ptr_q + 1'b1;
    if (ra) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wa && !ra)      cnt_d = cnt_q + 1'b1;
    else if (ra && !wa) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  rfphoenix_fifo_ram #(
    .WID (WID),
    .DEP (DEP),
    .AW  (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wa),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (di),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      // Head entry shows through directly; forced to zero while nothing is held.
      assign dout  = empty ? '0 : rdata;
      assign valid = ~empty;
    end else begin : g_reg
      logic [WID-1:0] dout_q, dout_d;
      logic           valid_q, valid_d;

      always_comb begin
        dout_d  = dout_q;
        valid_d = ra;
        if (ra) dout_d = rdata;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          dout_q  <= dout_d;
          valid_q <= valid_d;
        end
      end

      assign dout  = dout_q;
      assign valid = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_rfphoenix_param_fifo.sv
// Bench for rfphoenix_param_fifo: registered-read and FWFT instances driven in lockstep against a queue model.
module tb_rfphoenix_param_fifo;

  localparam int DEP = 16;

  logic        clk;
  logic        rst;
  logic        wr;
  logic        rd;
  logic [31:0] di;

  logic [31:0] dout0, dout1;
  logic        valid0, valid1;
  logic [4:0]  cnt0, cnt1;
  logic        empty0, empty1, full0, full1, afull0, afull1;
  logic        ovf0, ovf1, unf0, unf1;

  rfphoenix_param_fifo #(.WID(32), .DEP(16), .FWFT(0), .AFULL(14)) dut0 (
    .clk(clk), .rst(rst), .wr(wr), .di(di), .rd(rd),
    .dout(dout0), .valid(valid0), .cnt(cnt0), .empty(empty0), .full(full0),
    .almost_full(afull0), .overflow(ovf0), .underflow(unf0)
  );

  rfphoenix_param_fifo #(.WID(32), .DEP(16), .FWFT(1), .AFULL(4)) dut1 (
    .clk(clk), .rst(rst), .wr(wr), .di(di), .rd(rd),
    .dout(dout1), .valid(valid1), .cnt(cnt1), .empty(empty1), .full(full1),
    .almost_full(afull1), .overflow(ovf1), .underflow(unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: a queue of stored words plus the registered-read output state.
  logic [31:0] q[$];
  logic        m_ovf, m_unf, m_valid0;
  logic [31:0] m_dout0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_unf = 0; m_valid0 = 0; m_dout0 = '0;
  endtask

  task automatic model_step(input logic w, input logic r, input logic [31:0] d);
    int  sz;
    bit  can_read;
    sz       = q.size();
    can_read = r && (sz > 0);
    m_ovf    = w && (sz == DEP) && !can_read;
    m_unf    = r && (sz == 0);
    m_valid0 = can_read;
    if (can_read) m_dout0 = q.pop_front();
    if (w && (sz < DEP || can_read)) q.push_back(d);
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    check("cnt0", 64'(cnt0), 64'(sz));
    check("empty0", 64'(empty0), 64'(sz == 0));
    check("full0", 64'(full0), 64'(sz == DEP));
    check("afull0", 64'(afull0), 64'(sz >= 14));
    check("ovf0", 64'(ovf0), 64'(m_ovf));
    check("unf0", 64'(unf0), 64'(m_unf));
    check("valid0", 64'(valid0), 64'(m_valid0));
    if (m_valid0) check("dout0", 64'(dout0), 64'(m_dout0));
    check("cnt1", 64'(cnt1), 64'(sz));
    check("afull1", 64'(afull1), 64'(sz >= 4));
    check("ovf1", 64'(ovf1), 64'(m_ovf));
    check("unf1", 64'(unf1), 64'(m_unf));
    check("valid1", 64'(valid1), 64'(sz > 0));
    if (sz > 0) check("dout1", 64'(dout1), 64'(q[0]));
  endtask

  // Drive one cycle: inputs settle after an edge, the model advances at the next edge, outputs sampled 1 ns later.
  task automatic cycle(input logic w, input logic r, input logic [31:0] d);
    wr = w; rd = r; di = d;
    @(posedge clk);
    model_step(w, r, d);
    #1;
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] di;
    int          exp_cnt;
    logic        exp_full;
    logic        exp_ovf;
    logic        exp_unf;
    logic        exp_valid;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    int   n;
    rst = 1'b0; wr = 0; rd = 0; di = '0;
    model_reset();

    // 16 writes, one rejected write, 16 reads, an idle cycle, a read on empty.
    for (int i = 0; i < 16; i++) begin
      v = '{1'b1, 1'b0, 32'(i), i + 1, (i == 15), 1'b0, 1'b0, 1'b0, 32'h0};
      vecs.push_back(v);
    end
    v = '{1'b1, 1'b0, 32'hDEAD, 16, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs.push_back(v);
    for (int i = 0; i < 16; i++) begin
      v = '{1'b0, 1'b1, 32'h0, 15 - i, 1'b0, 1'b0, 1'b0, 1'b1, 32'(i)};
      vecs.push_back(v);
    end
    v = '{1'b0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs.push_back(v);
    v = '{1'b0, 1'b1, 32'h0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs.push_back(v);

    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt0", 64'(cnt0), 64'd0);
    check("rst_empty0", 64'(empty0), 64'd1);
    check("rst_full0", 64'(full0), 64'd0);
    check("rst_afull0", 64'(afull0), 64'd0);
    check("rst_valid0", 64'(valid0), 64'd0);
    check("rst_dout0", 64'(dout0), 64'd0);
    check("rst_valid1", 64'(valid1), 64'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].wr, vecs[i].rd, vecs[i].di);
      check($sformatf("vec%0d_cnt", i), 64'(cnt0), 64'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_full", i), 64'(full0), 64'(vecs[i].exp_full));
      check($sformatf("vec%0d_ovf", i), 64'(ovf0), 64'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_unf", i), 64'(unf0), 64'(vecs[i].exp_unf));
      check($sformatf("vec%0d_valid", i), 64'(valid0), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("vec%0d_dout", i), 64'(dout0), 64'(vecs[i].exp_dout));
      check_all();
      $display("vec %0d wr=%0b rd=%0b di=%0h cnt=%0d valid=%0b dout=%0h", i, vecs[i].wr, vecs[i].rd,
               vecs[i].di, cnt0, valid0, dout0);
    end

    // Steady state at cnt=8 with simultaneous read and write across pointer wrap.
    for (int i = 0; i < 8; i++) begin cycle(1, 0, 32'(100 + i)); check_all(); end
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 32'(200 + i));
      check_all();
      check("steady_cnt", 64'(cnt0), 64'd8);
      $display("steady %0d dout=%0h cnt=%0d", i, dout0, cnt0);
    end

    // Full plus read+write: accepted, no overflow. Then drain and hit empty with read+write.
    for (int i = 0; i < 8; i++) begin cycle(1, 0, 32'(300 + i)); check_all(); end
    cycle(1, 1, 32'h777);
    check_all();
    check("full_rw_cnt", 64'(cnt0), 64'd16);
    check("full_rw_ovf", 64'(ovf0), 64'd0);
    n = 0;
    while (q.size() > 0 && n < 40) begin cycle(0, 1, 32'h0); check_all(); n++; end
    cycle(1, 1, 32'h55);
    check_all();
    check("empty_rw_unf", 64'(unf0), 64'd1);
    check("empty_rw_cnt", 64'(cnt0), 64'd1);
    $display("empty rw unf=%0b cnt=%0d", unf0, cnt0);
    cycle(0, 1, 32'h0); check_all();

    // almost_full threshold edges.
    for (int i = 0; i < 13; i++) begin cycle(1, 0, 32'(400 + i)); check_all(); end
    check("af_at13", 64'(afull0), 64'd0);
    cycle(1, 0, 32'h500); check_all();
    check("af_at14", 64'(afull0), 64'd1);
    cycle(0, 1, 32'h0); check_all();
    check("af_back13", 64'(afull0), 64'd0);
    n = 0;
    while (q.size() > 0 && n < 40) begin cycle(0, 1, 32'h0); check_all(); n++; end

    // First-word fall-through on an empty FIFO.
    cycle(1, 0, 32'hA5); check_all();
    check("fwft_valid", 64'(valid1), 64'd1);
    check("fwft_dout", 64'(dout1), 64'hA5);
    cycle(0, 1, 32'h0); check_all();
    check("fwft_empty", 64'(empty1), 64'd1);
    check("fwft_valid_off", 64'(valid1), 64'd0);
    $display("fwft dout=%0h valid=%0b", dout1, valid1);

    // Randomised traffic, first biased toward writes, then toward reads.
    for (int i = 0; i < 400; i++) begin
      logic w, r;
      w = ($urandom_range(0, 99) < ((i < 200) ? 70 : 30));
      r = ($urandom_range(0, 99) < ((i < 200) ? 30 : 70));
      cycle(w, r, $urandom());
      check_all();
      $display("rand %0d wr=%0b rd=%0b cnt=%0d", i, w, r, cnt0);
    end

    // Asynchronous reset mid-burst at cnt=5.
    n = 0;
    while (q.size() > 0 && n < 40) begin cycle(0, 1, 32'h0); check_all(); n++; end
    for (int i = 0; i < 5; i++) begin cycle(1, 0, 32'(600 + i)); check_all(); end
    cycle(1, 1, 32'h606); check_all();
    wr = 1; rd = 1; di = 32'h607;
    #2 rst = 1'b0;
    #1;
    check("arst_cnt0", 64'(cnt0), 64'd0);
    check("arst_empty0", 64'(empty0), 64'd1);
    check("arst_valid0", 64'(valid0), 64'd0);
    check("arst_dout0", 64'(dout0), 64'd0);
    check("arst_cnt1", 64'(cnt1), 64'd0);
    check("arst_valid1", 64'(valid1), 64'd0);
    $display("async reset cnt=%0d empty=%0b valid=%0b", cnt0, empty0, valid0);
    wr = 0; rd = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    cycle(1, 0, 32'hBEEF); check_all();
    check("post_rst_cnt", 64'(cnt0), 64'd1);
    cycle(0, 1, 32'h0); check_all();
    check("post_rst_dout", 64'(dout0), 64'hBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
